// File: rtl/maxtree_seq_ctrl.sv
`timescale 1ns/1ps
// maxtree_seq_ctrl: job sequencer for the 64-lane pipelined max-reduction tree.
// Streams chunks into the tree with chunk/channel tags, folds the returned
// partial maxima into per-channel results and tracks the job-wide maximum.
module maxtree_seq_ctrl #(
    parameter int unsigned CHUNK_W = 8,
    parameter int unsigned CH_W    = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [CH_W-1:0]    cfg_num_ch,
    input  logic [CHUNK_W-1:0] cfg_chunks,
    output logic               busy,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [1023:0]      s_data,
    output logic [1023:0]      tree_tensor,
    output logic               tree_valid_in,
    output logic [15:0]        tree_tmax_in,
    output logic [15:0]        tree_chidx_in,
    input  logic [15:0]        tree_max,
    input  logic               tree_valid_out,
    input  logic [15:0]        tree_tmax_out,
    input  logic [15:0]        tree_chidx_out,
    output logic               ch_valid,
    output logic [15:0]        ch_max,
    output logic [CH_W-1:0]    ch_idx,
    output logic               done,
    output logic [15:0]        gmax
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CH_W-1:0]    num_ch_q, chn_q, num_ch_m1;
    logic [CHUNK_W-1:0] chunks_q, cc_q, chunks_m1;
    logic [15:0]        acc_q, folded;
    logic               accept, cfg_zero, issue, last_chunk, last_ch, ret_en, ret_last;

    // Handshake, counter wrap and return-fold decode
    always_comb begin
        busy       = (state_q != StIdle);
        s_ready    = (state_q == StRun);
        done       = (state_q == StDone);
        accept     = (state_q == StIdle) && start;
        cfg_zero   = (cfg_num_ch == '0) || (cfg_chunks == '0);
        issue      = s_valid && s_ready;
        chunks_m1  = chunks_q - 1'b1;
        num_ch_m1  = num_ch_q - 1'b1;
        last_chunk = (cc_q == chunks_m1);
        last_ch    = (chn_q == num_ch_m1);
        // Returns seen in IDLE are leftovers from an aborted job
        ret_en     = tree_valid_out && (state_q != StIdle);
        ret_last   = (tree_tmax_out == 16'(chunks_m1));
        // Chunk 0 starts a new channel, so it overwrites the accumulator
        folded     = ((tree_tmax_out == 16'd0) || (tree_max > acc_q)) ? tree_max : acc_q;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = cfg_zero ? StDone : StRun;
            StRun:   if (issue && last_chunk && last_ch) state_d = StDrain;
            StDrain: if (ch_valid && (ch_idx == num_ch_m1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state, latched job configuration and chunk/channel counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            num_ch_q <= '0;
            chunks_q <= '0;
            cc_q     <= '0;
            chn_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                num_ch_q <= cfg_num_ch;
                chunks_q <= cfg_chunks;
                cc_q     <= '0;
                chn_q    <= '0;
            end else if (issue) begin
                if (last_chunk) begin
                    cc_q  <= '0;
                    chn_q <= chn_q + 1'b1;
                end else begin
                    cc_q <= cc_q + 1'b1;
                end
            end
        end
    end

    // Registered chunk and tags towards the tree; held when nothing issues
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tree_valid_in <= 1'b0;
            tree_tensor   <= '0;
            tree_tmax_in  <= '0;
            tree_chidx_in <= '0;
        end else begin
            tree_valid_in <= issue;
            if (issue) begin
                tree_tensor   <= s_data;
                tree_tmax_in  <= 16'(cc_q);
                tree_chidx_in <= 16'(chn_q);
            end
        end
    end

    // Fold tree results into the channel accumulator and the job maximum
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q    <= '0;
            gmax     <= '0;
            ch_valid <= 1'b0;
            ch_max   <= '0;
            ch_idx   <= '0;
        end else begin
            ch_valid <= 1'b0;
            if (accept) begin
                gmax <= '0;
            end else if (ret_en) begin
                acc_q <= folded;
                if (folded > gmax) gmax <= folded;
                if (ret_last) begin
                    ch_valid <= 1'b1;
                    ch_max   <= folded;
                    ch_idx   <= tree_chidx_out[CH_W-1:0];
                end
            end
        end
    end

endmodule
